// File: rtl/fetch_unit_if.sv
// Instruction-ROM bus between the fetch stage and the instruction memory.
// The fetch stage (master) drives the address; the ROM (slave) returns the
// 16-bit word for that address combinationally in the same cycle.
//   imem_pc    : ROM address, driven by the fetch stage
//   imem_instr : ROM data for imem_pc, driven by the ROM
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;

    modport master (output imem_pc, input imem_instr);
    modport slave  (input imem_pc, output imem_instr);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the program counter, addresses the ROM and
// captures each fetched word with its PC into the IF/ID pipeline register.
// Handles stalls, branch/jump redirects (which flush IF/ID) and a HALT word
// that stops fetching until the next redirect.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   imem              : ROM bus (address out, combinational data in)
//   stall             : hold PC and IF/ID
//   redirect          : load redirect_pc and insert one bubble
//   redirect_pc       : redirect target
//   if_id_instr/pc    : registered instruction and its address
//   if_id_valid       : IF/ID holds a real instruction
//   halted            : fetch stopped on a HALT word
//   fetch_count       : instructions delivered since reset, saturating
module fetch_unit #(
    parameter int                   PC_W       = 8,
    parameter int                   INSTR_W    = 16,
    parameter logic [PC_W-1:0]      RESET_PC   = 8'h00,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [PC_W-1:0]     if_id_pc,
    output logic                if_id_valid,
    output logic                halted,
    output logic [15:0]         fetch_count
);
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state_r,  state_s;
    logic [PC_W-1:0]    pc_r,     pc_s;
    logic [INSTR_W-1:0] instr_r,  instr_s;
    logic [PC_W-1:0]    ifpc_r,   ifpc_s;
    logic               valid_r,  valid_s;
    logic               halted_r;
    logic [15:0]        count_r,  count_s;

    assign imem.imem_pc = pc_r;
    assign if_id_instr  = instr_r;
    assign if_id_pc     = ifpc_r;
    assign if_id_valid  = valid_r;
    assign halted       = halted_r;
    assign fetch_count  = count_r;

    // Next-state logic: redirect beats stall, stall beats the normal fetch.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        ifpc_s  = ifpc_r;
        valid_s = valid_r;
        count_s = count_r;
        if (redirect) begin
            // IF/ID payload is left as-is; only the valid bit is flushed.
            pc_s    = redirect_pc;
            valid_s = 1'b0;
            state_s = RUN;
        end else if (stall) begin
            state_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    instr_s = imem.imem_instr;
                    ifpc_s  = pc_r;
                    valid_s = 1'b1;
                    if (count_r != 16'hFFFF) begin
                        count_s = count_r + 16'd1;
                    end else begin
                        count_s = count_r;
                    end
                    // The HALT word is delivered but the PC parks on it.
                    if (imem.imem_instr == HALT_INSTR) begin
                        state_s = HALTED;
                    end else begin
                        pc_s = pc_r + PC_W'(1);
                    end
                end
                HALTED: begin
                    valid_s = 1'b0;
                end
                default: begin
                    state_s = RUN;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // Pipeline and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            instr_r  <= {INSTR_W{1'b0}};
            ifpc_r   <= {PC_W{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            count_r  <= 16'd0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            ifpc_r   <= ifpc_s;
            valid_r  <= valid_s;
            halted_r <= (state_s == HALTED);
            count_r  <= count_s;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] rom [256];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit_if #(.PC_W(8), .INSTR_W(16)) imem ();
    assign imem.imem_instr = rom[imem.imem_pc];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: the fetch rules expressed directly on plain variables.
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_ifpc;
    logic        m_valid;
    logic        m_halt;
    logic [15:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 8'h00; m_instr <= 16'h0000; m_ifpc <= 8'h00;
            m_valid <= 1'b0; m_halt <= 1'b0; m_cnt <= 16'h0000;
        end else if (redirect) begin
            m_pc <= redirect_pc; m_valid <= 1'b0; m_halt <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (!m_halt) begin
            m_instr <= rom[m_pc];
            m_ifpc  <= m_pc;
            m_valid <= 1'b1;
            m_cnt   <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (rom[m_pc] == 16'hFFFF) m_halt <= 1'b1;
            else                       m_pc   <= m_pc + 8'd1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("imem_pc",     32'(imem.imem_pc), 32'(m_pc));
        chk("if_id_valid", 32'(if_id_valid),  32'(m_valid));
        chk("halted",      32'(halted),       32'(m_halt));
        chk("fetch_count", 32'(fetch_count),  32'(m_cnt));
        chk("if_id_pc",    32'(if_id_pc),     32'(m_ifpc));
        chk("if_id_instr", 32'(if_id_instr),  32'(m_instr));
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [7:0] target, input logic with_stall);
        redirect = 1'b1; redirect_pc = target; stall = with_stall;
        edge_step();
        redirect = 1'b0; stall = 1'b0;
    endtask

    logic [15:0] saved_cnt;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);

        // Reset state
        repeat (2) edge_step();
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_pc",    32'(imem.imem_pc), 32'h00);
        chk("rst_halt",  32'(halted), 32'd0);
        rst = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            edge_step();
            chk("seq_pc",    32'(if_id_pc), 32'(i));
            chk("seq_instr", 32'(if_id_instr), 32'h1000 + 32'(i));
            chk("seq_valid", 32'(if_id_valid), 32'd1);
        end
        chk("seq_count", 32'(fetch_count), 32'd4);

        // Stall at pc=5
        edge_step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("stall_imem_pc", 32'(imem.imem_pc), 32'h05);
            chk("stall_ifid_pc", 32'(if_id_pc), 32'h04);
            chk("stall_count",   32'(fetch_count), 32'd5);
        end
        stall = 1'b0;
        edge_step();
        chk("unstall_pc", 32'(if_id_pc), 32'h05);

        // Redirect under stall
        do_redirect(8'h40, 1'b1);
        chk("redir_imem_pc", 32'(imem.imem_pc), 32'h40);
        chk("redir_bubble",  32'(if_id_valid), 32'd0);
        edge_step();
        chk("redir_target", 32'(if_id_pc), 32'h40);
        chk("redir_valid",  32'(if_id_valid), 32'd1);

        // Halt then resume
        rom[3] = 16'hFFFF;
        do_redirect(8'h01, 1'b0);
        edge_step(); edge_step(); edge_step();
        chk("halt_pc",    32'(if_id_pc), 32'h03);
        chk("halt_instr", 32'(if_id_instr), 32'hFFFF);
        chk("halt_valid", 32'(if_id_valid), 32'd1);
        chk("halt_flag",  32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            edge_step();
            chk("halted_valid", 32'(if_id_valid), 32'd0);
            chk("halted_pc",    32'(imem.imem_pc), 32'h03);
        end
        do_redirect(8'h10, 1'b0);
        chk("resume_halt",  32'(halted), 32'd0);
        chk("resume_valid", 32'(if_id_valid), 32'd0);
        edge_step();
        chk("resume_pc", 32'(if_id_pc), 32'h10);

        // PC wrap
        do_redirect(8'hFE, 1'b0);
        edge_step(); chk("wrap_fe", 32'(if_id_pc), 32'hFE);
        edge_step(); chk("wrap_ff", 32'(if_id_pc), 32'hFF);
        edge_step(); chk("wrap_00", 32'(if_id_pc), 32'h00);

        // Redirect versus HALT fetch
        do_redirect(8'h03, 1'b0);
        saved_cnt = fetch_count;
        do_redirect(8'h20, 1'b0);
        chk("rvh_halt",  32'(halted), 32'd0);
        chk("rvh_valid", 32'(if_id_valid), 32'd0);
        chk("rvh_count", 32'(fetch_count), 32'(saved_cnt));
        edge_step();
        chk("rvh_next", 32'(if_id_pc), 32'h20);

        // Randomised phase
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 8'($urandom);
            edge_step();
        end
        stall = 1'b0; redirect = 1'b0;

        // Asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(if_id_valid), 32'd0);
        chk("arst_count", 32'(fetch_count), 32'd0);
        chk("arst_pc",    32'(imem.imem_pc), 32'h00);
        chk("arst_halt",  32'(halted), 32'd0);
        chk("arst_ifpc",  32'(if_id_pc), 32'h00);
        chk("arst_instr", 32'(if_id_instr), 32'h0000);
        #3;
        rst = 1'b0;
        repeat (20) begin
            stall = ($urandom_range(0, 3) == 0);
            edge_step();
        end
        stall = 1'b0;

        edge_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
